history_ram_bank: RTL and testbench

- One bank of the decompressor history buffer, with sizes set by parameters. It replaces the fixed 16-bank, 8-byte, 512-deep result RAM.
- Stores literal bytes with a per-byte phase tag.
- Serves copy reads through a 4-stage pipeline that aligns the data to the destination and splits it into even and odd word outputs for the two destination banks.
- Reports unresolved bytes, and runs a page-clear sweep that reports its own status and counts dropped writes.

---
 rtl/history_ram_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_history_ram_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/history_ram_bank.sv
// One bank of the decompressor history buffer: tagged literal storage, a 4-stage
// copy-read alignment pipeline with even/odd word split, and a page-clear sweep.
module history_ram_bank #(
  parameter int BLOCKNUM   = 0,
  parameter int NUM_BLOCKS = 16,
  parameter int WORD_BYTES = 8,
  parameter int DEPTH      = 512,
  parameter int OFFSET_W   = 16
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               page_finish,
  input  logic                                               block_out_finish,
  input  logic                                               rd_en,
  input  logic                                               valid_wr_in,
  input  logic [8*WORD_BYTES-1:0]                            lit_in,
  input  logic [$clog2(DEPTH)-1:0]                           lit_address,
  input  logic [WORD_BYTES-1:0]                              lit_valid,
  input  logic                                               valid_rd_in,
  input  logic [$clog2(DEPTH)-1:0]                           copy_address,
  input  logic [WORD_BYTES-1:0]                              copy_valid_in,
  input  logic [OFFSET_W-1:0]                                copy_offset_in,
  output logic                                               clear_busy,
  output logic [7:0]                                         wr_drop_cnt,
  output logic                                               unsolved_valid_out,
  output logic [$clog2(DEPTH)+WORD_BYTES+OFFSET_W-1:0]       unsolved_token_out,
  output logic                                               even_valid_out,
  output logic                                               odd_valid_out,
  output logic [8*WORD_BYTES-1:0]                            even_data_out,
  output logic [8*WORD_BYTES-1:0]                            odd_data_out,
  output logic [WORD_BYTES-1:0]                              even_hit_out,
  output logic [WORD_BYTES-1:0]                              odd_hit_out,
  output logic [$clog2(DEPTH)-1:0]                           even_address_out,
  output logic [$clog2(DEPTH)-1:0]                           odd_address_out,
  output logic [NUM_BLOCKS-1:0]                              ram_select_out,
  output logic [8*WORD_BYTES-1:0]                            data_out
);
  localparam int BB = $clog2(NUM_BLOCKS);
  localparam int WB = $clog2(WORD_BYTES);
  localparam int DW = 8 * WORD_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int WW = OFFSET_W - WB;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0]         addr;
    logic [WORD_BYTES-1:0] mask;
    logic [OFFSET_W-1:0]   off;
  } copy_req_t;

  state_t        state;
  logic [AW-1:0] sweep_cnt;
  logic          phase;

  // Each byte is stored as {tag, data}; tag XOR phase gives byte validity.
  logic [WORD_BYTES-1:0][8:0] mem [DEPTH];
  logic [WORD_BYTES-1:0][8:0] rd_word;
  logic [WORD_BYTES-1:0][8:0] wr_word;
  logic [AW-1:0]              wr_addr;
  logic                       wr_en;
  logic [DW-1:0]              rd_data;
  logic [WORD_BYTES-1:0]      rd_valid;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = lit_address;
    wr_word = '0;
    if (state == SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = sweep_cnt;
    end else if (valid_wr_in) begin
      wr_en = 1'b1;
      for (int i = 0; i < WORD_BYTES; i++)
        wr_word[i] = {lit_valid[i] ^ phase, lit_in[8*i +: 8]};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Read-before-write: a same-address write is not visible until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_word <= '0;
    else if (rd_en) rd_word <= mem[copy_address];
  end

  always_comb begin
    rd_data  = '0;
    rd_valid = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rd_data[8*i +: 8] = rd_word[i][7:0];
      rd_valid[i]       = rd_word[i][8] ^ phase;
    end
  end

  assign data_out = rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sweep_cnt   <= '0;
      clear_busy  <= 1'b0;
      wr_drop_cnt <= '0;
      phase       <= 1'b0;
    end else begin
      if (page_finish)           phase <= 1'b0;
      else if (block_out_finish) phase <= ~phase;
      case (state)
        IDLE: if (page_finish) begin
          state      <= SWEEP;
          sweep_cnt  <= '0;
          clear_busy <= 1'b1;
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + AW'(1);
          if (valid_wr_in && wr_drop_cnt != 8'hFF) wr_drop_cnt <= wr_drop_cnt + 8'd1;
          if (sweep_cnt == AW'(DEPTH - 1)) begin
            state      <= DONE;
            clear_busy <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:1]              vld_pipe;
  copy_req_t               req1, req2;
  logic [OFFSET_W-1:0]     des1, des2;
  logic [DW-1:0]           data2;
  logic [WORD_BYTES-1:0]   hit2;
  logic [WW-1:0]           word3;
  logic [2*DW-1:0]         shifted3;
  logic [2*WORD_BYTES-1:0] hit16_3;
  logic [WORD_BYTES-1:0]   miss2;

  assign miss2 = hit2 ^ req2.mask;

  logic [WW-1:0]           w0;
  logic [AW-1:0]           a0, a1;
  logic [BB-1:0]           bank1;
  logic [NUM_BLOCKS-1:0]   sel;
  logic [DW-1:0]           hi_data, lo_data;
  logic [WORD_BYTES-1:0]   hi_hit, lo_hit;

  // Upper half of the shifted pair lands in word W0, lower half in W0+1.
  always_comb begin
    w0      = word3;
    a0      = w0[WW-1:BB];
    a1      = AW'((w0 + WW'(1)) >> BB);
    bank1   = w0[BB-1:0] + BB'(1);
    hi_data = shifted3[2*DW-1:DW];
    lo_data = shifted3[DW-1:0];
    hi_hit  = hit16_3[2*WORD_BYTES-1:WORD_BYTES];
    lo_hit  = hit16_3[WORD_BYTES-1:0];
    sel     = '0;
    sel[w0[BB-1:0]] = 1'b1;
    sel[bank1]      = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe           <= '0;
      req1               <= '0;
      req2               <= '0;
      des1               <= '0;
      des2               <= '0;
      data2              <= '0;
      hit2               <= '0;
      word3              <= '0;
      shifted3           <= '0;
      hit16_3            <= '0;
      unsolved_valid_out <= 1'b0;
      unsolved_token_out <= '0;
      even_valid_out     <= 1'b0;
      odd_valid_out      <= 1'b0;
      even_data_out      <= '0;
      odd_data_out       <= '0;
      even_hit_out       <= '0;
      odd_hit_out        <= '0;
      even_address_out   <= '0;
      odd_address_out    <= '0;
      ram_select_out     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[2:1], valid_rd_in};
      req1     <= {copy_address, copy_valid_in, copy_offset_in};
      des1     <= {copy_address, BB'(BLOCKNUM), {WB{1'b0}}} + copy_offset_in;

      req2  <= req1;
      des2  <= des1;
      data2 <= rd_data;
      hit2  <= rd_valid & req1.mask;

      unsolved_valid_out <= vld_pipe[2] && (miss2 != '0);
      unsolved_token_out <= {req2.addr, miss2, req2.off};
      word3    <= des2[OFFSET_W-1:WB];
      shifted3 <= {data2, {DW{1'b0}}} >> {des2[WB-1:0], 3'b000};
      hit16_3  <= {hit2, {WORD_BYTES{1'b0}}} >> des2[WB-1:0];

      ram_select_out <= sel;
      if (!w0[0]) begin
        even_data_out    <= hi_data;
        even_hit_out     <= hi_hit;
        even_address_out <= a0;
        even_valid_out   <= vld_pipe[3] && (hi_hit != '0);
        odd_data_out     <= lo_data;
        odd_hit_out      <= lo_hit;
        odd_address_out  <= a1;
        odd_valid_out    <= vld_pipe[3] && (lo_hit != '0);
      end else begin
        even_data_out    <= lo_data;
        even_hit_out     <= lo_hit;
        even_address_out <= a1;
        even_valid_out   <= vld_pipe[3] && (lo_hit != '0);
        odd_data_out     <= hi_data;
        odd_hit_out      <= hi_hit;
        odd_address_out  <= a0;
        odd_valid_out    <= vld_pipe[3] && (hi_hit != '0);
      end
    end
  end

endmodule

// File: tb/tb_history_ram_bank.sv
// Randomized bench for history_ram_bank against a per-cycle byte-level reference model.
module tb_history_ram_bank;
  localparam int NB = 16, WBY = 8, DEP = 512, OW = 16, BLK = 15;
  localparam int AW = 9, DW = 64, TW = AW + WBY + OW;

  logic clk = 1'b0, rst = 1'b1;
  logic page_finish = 0, block_out_finish = 0, rd_en = 0, valid_wr_in = 0, valid_rd_in = 0;
  logic [DW-1:0]  lit_in = '0;
  logic [AW-1:0]  lit_address = '0, copy_address = '0;
  logic [WBY-1:0] lit_valid = '0, copy_valid_in = '0;
  logic [OW-1:0]  copy_offset_in = '0;
  logic           clear_busy, unsolved_valid_out, even_valid_out, odd_valid_out;
  logic [7:0]     wr_drop_cnt;
  logic [TW-1:0]  unsolved_token_out;
  logic [DW-1:0]  even_data_out, odd_data_out, data_out;
  logic [WBY-1:0] even_hit_out, odd_hit_out;
  logic [AW-1:0]  even_address_out, odd_address_out;
  logic [NB-1:0]  ram_select_out;

  always #5 clk = ~clk;

  history_ram_bank #(.BLOCKNUM(BLK), .NUM_BLOCKS(NB), .WORD_BYTES(WBY), .DEPTH(DEP), .OFFSET_W(OW)) dut (
    .clk(clk), .rst(rst), .page_finish(page_finish), .block_out_finish(block_out_finish),
    .rd_en(rd_en), .valid_wr_in(valid_wr_in), .lit_in(lit_in), .lit_address(lit_address),
    .lit_valid(lit_valid), .valid_rd_in(valid_rd_in), .copy_address(copy_address),
    .copy_valid_in(copy_valid_in), .copy_offset_in(copy_offset_in), .clear_busy(clear_busy),
    .wr_drop_cnt(wr_drop_cnt), .unsolved_valid_out(unsolved_valid_out),
    .unsolved_token_out(unsolved_token_out), .even_valid_out(even_valid_out),
    .odd_valid_out(odd_valid_out), .even_data_out(even_data_out), .odd_data_out(odd_data_out),
    .even_hit_out(even_hit_out), .odd_hit_out(odd_hit_out), .even_address_out(even_address_out),
    .odd_address_out(odd_address_out), .ram_select_out(ram_select_out), .data_out(data_out));

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit v; bit ev; bit ov;
    logic [DW-1:0] ed, od; logic [WBY-1:0] eh, oh; logic [AW-1:0] ea, oa; logic [NB-1:0] sel;
  } out_t;
  typedef struct { bit uv; logic [TW-1:0] tok; } uns_t;

  // Reference model: byte data, stored tags, and whether each word is defined yet.
  logic [DW-1:0]  m_data [DEP];
  logic [WBY-1:0] m_tag  [DEP];
  bit             m_known[DEP];
  bit             m_phase, m_dout_known;
  logic [DW-1:0]  m_dout;
  int             m_mode, m_cnt, m_drop, cyc;   // m_mode: 0 idle, 1 sweeping, 2 done
  out_t           exp_out[int];
  uns_t           exp_uns[int];

  function automatic logic [7:0] byte_of(input logic [DW-1:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_cnt = 0; m_drop = 0; m_dout = '0; m_dout_known = 1;
    for (int i = 0; i < DEP; i++) m_known[i] = 0;
    exp_out.delete(); exp_uns.delete();
  endtask

  task automatic step();
    logic [DW-1:0] sd, up_d, lo_d; logic [WBY-1:0] stag, hit, up_h, lo_h;
    bit sk; int des, s, w0, w1; out_t o; uns_t u;
    sd = m_data[copy_address]; stag = m_tag[copy_address]; sk = m_known[copy_address];
    if (m_mode == 1) begin
      if (valid_wr_in && m_drop < 255) m_drop++;
      m_data[m_cnt] = '0; m_tag[m_cnt] = '0; m_known[m_cnt] = 1;
      m_cnt++;
      if (m_cnt == DEP) m_mode = 2;
    end else begin
      if (valid_wr_in) begin
        m_data[lit_address] = lit_in;
        m_tag[lit_address]  = lit_valid ^ {WBY{m_phase}};
        m_known[lit_address] = 1;
      end
      if (m_mode == 2) m_mode = 0;
      else if (page_finish) begin m_mode = 1; m_cnt = 0; end
    end
    if (page_finish) m_phase = 0;
    else if (block_out_finish) m_phase = ~m_phase;
    if (rd_en) begin m_dout = sd; m_dout_known = sk; end
    if (valid_rd_in) begin
      hit = (stag ^ {WBY{m_phase}}) & copy_valid_in;
      des = (int'(copy_address) * NB * WBY + BLK * WBY + int'(copy_offset_in)) % (1 << OW);
      s = des % WBY; w0 = des / WBY; w1 = (w0 + 1) % (1 << (OW - 3));
      up_d = '0; lo_d = '0; up_h = '0; lo_h = '0;
      for (int j = 0; j < WBY; j++) begin
        if (j + s < WBY) begin up_d[8*j +: 8] = byte_of(sd, j + s); up_h[j] = hit[j + s]; end
        else begin lo_d[8*j +: 8] = byte_of(sd, j + s - WBY); lo_h[j] = hit[j + s - WBY]; end
      end
      o.v = 1;
      o.sel = '0; o.sel[w0 % NB] = 1'b1; o.sel[(w0 + 1) % NB] = 1'b1;
      if (w0 % 2 == 0) begin
        o.ed = up_d; o.eh = up_h; o.ea = AW'(w0 / NB); o.od = lo_d; o.oh = lo_h; o.oa = AW'(w1 / NB);
      end else begin
        o.ed = lo_d; o.eh = lo_h; o.ea = AW'(w1 / NB); o.od = up_d; o.oh = up_h; o.oa = AW'(w0 / NB);
      end
      o.ev = (o.eh != 0); o.ov = (o.oh != 0);
      u.uv = ((copy_valid_in & ~hit) != 0);
      u.tok = {copy_address, copy_valid_in & ~hit, copy_offset_in};
      exp_out[cyc + 3] = o; exp_uns[cyc + 2] = u;
    end
    @(posedge clk); #1;
    check("clear_busy", clear_busy, m_mode == 1);
    check("wr_drop_cnt", wr_drop_cnt, m_drop);
    if (m_dout_known) check("data_out", data_out, m_dout);
    if (exp_uns.exists(cyc) && exp_uns[cyc].uv) begin
      check("unsolved_valid", unsolved_valid_out, 1);
      check("unsolved_token", unsolved_token_out, exp_uns[cyc].tok);
    end else check("unsolved_valid", unsolved_valid_out, 0);
    if (exp_out.exists(cyc)) begin
      o = exp_out[cyc];
      check("even_valid", even_valid_out, o.ev);   check("odd_valid", odd_valid_out, o.ov);
      check("even_data", even_data_out, o.ed);     check("odd_data", odd_data_out, o.od);
      check("even_hit", even_hit_out, o.eh);       check("odd_hit", odd_hit_out, o.oh);
      check("even_address", even_address_out, o.ea); check("odd_address", odd_address_out, o.oa);
      check("ram_select", ram_select_out, o.sel);
    end else begin
      check("even_valid_idle", even_valid_out, 0); check("odd_valid_idle", odd_valid_out, 0);
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    page_finish = 0; block_out_finish = 0; valid_wr_in = 0; valid_rd_in = 0; rd_en = 1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WBY-1:0] lv);
    idle_inputs(); valid_wr_in = 1; lit_address = a; lit_in = d; lit_valid = lv; step();
  endtask

  task automatic read_word(input logic [AW-1:0] a, input logic [WBY-1:0] cv, input logic [OW-1:0] off);
    idle_inputs(); valid_rd_in = 1; copy_address = a; copy_valid_in = cv; copy_offset_in = off; step();
  endtask

  initial begin
    int busy_cnt;
    model_reset(); cyc = 0;
    rst = 1; rd_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clear_busy", clear_busy, 0);   check("rst_drop", wr_drop_cnt, 0);
    check("rst_unsolved", unsolved_valid_out, 0); check("rst_token", unsolved_token_out, 0);
    check("rst_even_valid", even_valid_out, 0);   check("rst_odd_valid", odd_valid_out, 0);
    check("rst_even_data", even_data_out, 0);     check("rst_ram_select", ram_select_out, 0);
    check("rst_data_out", data_out, 0);
    @(negedge clk); rst = 0;

    // Clear sweep: busy window length, three dropped writes, re-trigger ignored.
    busy_cnt = 0;
    idle_inputs(); page_finish = 1; step();
    if (clear_busy) busy_cnt++;
    for (int i = 0; i < DEP + 3; i++) begin
      idle_inputs();
      valid_wr_in = (i == 10 || i == 100 || i == 300);
      lit_address = AW'(i); lit_in = {$urandom, $urandom}; lit_valid = 8'hFF;
      page_finish = (i == 50);
      step();
      if (clear_busy) busy_cnt++;
    end
    check("busy_cycles", busy_cnt, DEP);
    check("drops_after_sweep", wr_drop_cnt, 3);

    // Aligned copy and a 3-byte shift of the same word.
    write_word(5, 64'h1122334455667788, 8'hFF);
    read_word(5, 8'hFF, 0);
    read_word(5, 8'hFF, 3);
    idle_inputs(); repeat (4) step();

    // Bank 15 line 0 plus one word of offset wraps into bank 0 on line 1.
    write_word(0, 64'hA5A5_0102_0304_5A5A, 8'hFF);
    read_word(0, 8'hFF, 8);
    idle_inputs(); repeat (3) step();
    check("wrap_ram_select", ram_select_out, 16'h0003);
    check("wrap_even_address", even_address_out, 1);
    check("wrap_even_data", even_data_out, 64'hA5A5_0102_0304_5A5A);

    // Unwritten (swept) address: all requested bytes miss.
    read_word(7, 8'h0F, 16'h0040);
    idle_inputs(); step(); step();
    check("miss_unsolved_valid", unsolved_valid_out, 1);
    check("miss_mask", unsolved_token_out[OW +: WBY], 8'h0F);
    idle_inputs(); repeat (2) step();

    // Phase flip invalidates bytes written in the old phase.
    write_word(9, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    idle_inputs(); block_out_finish = 1; step();
    read_word(9, 8'hFF, 0);
    idle_inputs(); step(); step();
    check("phase_miss_mask", unsolved_token_out[OW +: WBY], 8'hFF);
    idle_inputs(); repeat (2) step();
    idle_inputs(); block_out_finish = 1; step();

    // Random mixed traffic on a small address window to force collisions.
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      block_out_finish = ($urandom_range(0, 31) == 0);
      valid_wr_in = $urandom_range(0, 1);
      lit_address = AW'($urandom_range(0, 15));
      lit_in = {$urandom, $urandom};
      lit_valid = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      valid_rd_in = $urandom_range(0, 1);
      rd_en = valid_rd_in | 1'($urandom_range(0, 1));
      copy_address = AW'($urandom_range(0, 15));
      copy_valid_in = 8'($urandom);
      copy_offset_in = ($urandom_range(0, 1) == 0) ? OW'($urandom_range(0, 31)) : OW'($urandom);
      step();
    end
    idle_inputs(); repeat (4) step();

    // Reset in the middle of a sweep aborts it immediately.
    idle_inputs(); page_finish = 1; step();
    idle_inputs(); repeat (20) step();
    check("sweep_running", clear_busy, 1);
    rst = 1; #1;
    check("abort_clear_busy", clear_busy, 0);
    check("abort_drop", wr_drop_cnt, 0);
    check("abort_even_valid", even_valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
